// File: rtl/jtframe_i2s_tx_if.sv
// Sample/strobe side and I2S pin side of the NeptUno audio output stage.
// The DUT uses the slave modport; the game/bench side uses master.
interface jtframe_i2s_tx_if;
  logic [15:0] snd_left;
  logic [15:0] snd_right;
  logic        sample_stb;
  logic        frame_req;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDIN;

  modport master (
    output snd_left, snd_right, sample_stb,
    input  frame_req, MCLK, SCLK, LRCLK, SDIN
  );

  modport slave (
    input  snd_left, snd_right, sample_stb,
    output frame_req, MCLK, SCLK, LRCLK, SDIN
  );
endinterface

// File: rtl/jtframe_i2s_tx.sv
// Philips I2S transmitter: 16-bit stereo samples in, MCLK/SCLK/LRCLK/SDIN out.
// Define JTFRAME_I2S_MONO_EN to send the L/R average on both channels.
module jtframe_i2s_tx #(
  parameter logic SIGNED_SND = 1'b0,
  parameter int   MCLK_HALF  = 1,
  parameter int   SCLK_HALF  = 4
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  jtframe_i2s_tx_if.slave   bus
);
  localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int SW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [MW-1:0] MCLK_TOP = MW'(MCLK_HALF - 1);
  localparam logic [SW-1:0] SCLK_TOP = SW'(SCLK_HALF - 1);

  logic [MW-1:0]      r_mclk_cnt;
  logic               r_mclk;
  logic [SW-1:0]      r_sclk_cnt;
  logic               r_sclk;
  logic [5:0]         r_bit_cnt;
  logic               r_lrclk;
  logic               r_sdin;
  logic               r_frame_req;
  logic signed [15:0] r_hold_l;
  logic signed [15:0] r_hold_r;
  logic signed [15:0] r_word_l;
  logic signed [15:0] r_word_r;

  logic               w_sclk_tick;
  logic [5:0]         w_bit_nxt;
  logic [4:0]         w_half;
  logic [3:0]         w_idx;
  logic signed [15:0] w_word;
  logic               w_sdin_nxt;

  function automatic logic signed [15:0] sign_fix(input logic [15:0] s);
    sign_fix = SIGNED_SND ? s : {~s[15], s[14:0]};
  endfunction

`ifdef JTFRAME_I2S_MONO_EN
  logic signed [15:0] w_mono;

  // Sum in 17 bits so the average never overflows; dropping the LSB is >>> 1.
  function automatic logic signed [15:0] mono_avg(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
    logic signed [16:0] sum;
    sum      = {a[15], a} + {b[15], b};
    mono_avg = sum[16:1];
  endfunction

  assign w_mono = mono_avg(r_hold_l, r_hold_r);
`endif

  assign w_sclk_tick = (r_sclk_cnt == SCLK_TOP);
  assign w_bit_nxt   = r_bit_cnt + 6'd1;
  assign w_half      = w_bit_nxt[4:0];
  assign w_idx       = 4'(5'd16 - w_half);
  assign w_word      = w_bit_nxt[5] ? r_word_r : r_word_l;

  // Philips framing: half-slot 0 is the one-bit delay, 1..16 carry MSB..LSB.
  always_comb begin
    w_sdin_nxt = 1'b0;
    if (w_half >= 5'd1 && w_half <= 5'd16)
      w_sdin_nxt = w_word[w_idx];
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_mclk_cnt <= '0;
      r_mclk     <= 1'b0;
    end else if (r_mclk_cnt == MCLK_TOP) begin
      r_mclk_cnt <= '0;
      r_mclk     <= ~r_mclk;
    end else begin
      r_mclk_cnt <= r_mclk_cnt + MW'(1);
    end
  end

  // Everything framed advances on the SCLK falling toggle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_cnt  <= '0;
      r_sclk      <= 1'b0;
      r_bit_cnt   <= 6'd63;
      r_lrclk     <= 1'b0;
      r_sdin      <= 1'b0;
      r_frame_req <= 1'b0;
    end else begin
      r_frame_req <= 1'b0;
      if (w_sclk_tick) begin
        r_sclk_cnt <= '0;
        r_sclk     <= ~r_sclk;
        if (r_sclk) begin
          r_bit_cnt   <= w_bit_nxt;
          r_lrclk     <= w_bit_nxt[5];
          r_sdin      <= w_sdin_nxt;
          r_frame_req <= (w_bit_nxt == 6'd0);
        end
      end else begin
        r_sclk_cnt <= r_sclk_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else if (bus.sample_stb) begin
      r_hold_l <= sign_fix(bus.snd_left);
      r_hold_r <= sign_fix(bus.snd_right);
    end
  end

  // Load one cycle after the wrap, so a strobe seen during frame_req
  // lands in the holding registers too late for this frame.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_word_l <= '0;
      r_word_r <= '0;
    end else if (r_frame_req) begin
`ifdef JTFRAME_I2S_MONO_EN
      r_word_l <= w_mono;
      r_word_r <= w_mono;
`else
      r_word_l <= r_hold_l;
      r_word_r <= r_hold_r;
`endif
    end
  end

  assign bus.MCLK      = r_mclk;
  assign bus.SCLK      = r_sclk;
  assign bus.LRCLK     = r_lrclk;
  assign bus.SDIN      = r_sdin;
  assign bus.frame_req = r_frame_req;
endmodule

// File: tb/tb_jtframe_i2s_tx.sv
// Directed bench for jtframe_i2s_tx: a signed and an offset-binary instance
// run side by side against a cycle-exact model of the I2S waveform.
module tb_jtframe_i2s_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   k = 0;

  always #5 clk = ~clk;

  jtframe_i2s_tx_if if_s ();
  jtframe_i2s_tx_if if_u ();

  jtframe_i2s_tx #(.SIGNED_SND(1'b1), .MCLK_HALF(1), .SCLK_HALF(4)) dut_s (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .bus     (if_s)
  );

  jtframe_i2s_tx #(.SIGNED_SND(1'b0), .MCLK_HALF(1), .SCLK_HALF(4)) dut_u (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .bus     (if_u)
  );

`ifdef JTFRAME_I2S_MONO_EN
  localparam logic [15:0] S0L = 16'h7FFF, S0R = 16'h0001;
  localparam logic [15:0] S1L = 16'h8000, S1R = 16'h8000;
  localparam logic [15:0] S2L = 16'h1111, S2R = 16'h2222;
  localparam logic [15:0] S3L = 16'hFFFF, S3R = 16'h0000;
`else
  localparam logic [15:0] S0L = 16'hA5C3, S0R = 16'h0001;
  localparam logic [15:0] S1L = 16'h1234, S1R = 16'h0001;
  localparam logic [15:0] S2L = 16'h5555, S2R = 16'hAAAA;
  localparam logic [15:0] S3L = 16'h0F0F, S3R = 16'hF0F0;
`endif

  logic [15:0] exp_sl [5];
  logic [15:0] exp_sr [5];
  logic [15:0] exp_ul [5];
  logic [15:0] exp_ur [5];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t k=%0d got=%h expected=%h", tag, $time, k, got, exp);
    end
  endtask

  function automatic logic exp_sdin(input int b, input logic [15:0] wl, input logic [15:0] wr);
    int h;
    logic [15:0] w;
    h = b % 32;
    w = (b >= 32) ? wr : wl;
    if (h >= 1 && h <= 16) return w[16 - h];
    return 1'b0;
  endfunction

  task automatic check_cycle();
    logic e_m, e_s, e_fr, e_lr, e_dsl, e_dsu;
    int m, b, f;
    e_m  = ((k % 2) == 1);
    e_s  = (((k / 4) % 2) == 1);
    e_fr = (k >= 8) && (((k - 8) % 512) == 0);
    e_lr = 1'b0;
    e_dsl = 1'b0;
    e_dsu = 1'b0;
    if (k >= 8) begin
      m = k / 8;
      b = (m - 1) % 64;
      f = (m - 1) / 64;
      if (f > 4) f = 4;
      e_lr  = (b >= 32);
      e_dsl = exp_sdin(b, exp_sl[f], exp_sr[f]);
      e_dsu = exp_sdin(b, exp_ul[f], exp_ur[f]);
    end
    chk("MCLK_s",  16'(if_s.MCLK),      16'(e_m));
    chk("SCLK_s",  16'(if_s.SCLK),      16'(e_s));
    chk("FREQ_s",  16'(if_s.frame_req), 16'(e_fr));
    chk("LRCLK_s", 16'(if_s.LRCLK),     16'(e_lr));
    chk("SDIN_s",  16'(if_s.SDIN),      16'(e_dsl));
    chk("MCLK_u",  16'(if_u.MCLK),      16'(e_m));
    chk("SCLK_u",  16'(if_u.SCLK),      16'(e_s));
    chk("FREQ_u",  16'(if_u.frame_req), 16'(e_fr));
    chk("LRCLK_u", 16'(if_u.LRCLK),     16'(e_lr));
    chk("SDIN_u",  16'(if_u.SDIN),      16'(e_dsu));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_MCLK"},  16'({if_s.MCLK, if_u.MCLK}),           16'h0);
    chk({tag, "_SCLK"},  16'({if_s.SCLK, if_u.SCLK}),           16'h0);
    chk({tag, "_LRCLK"}, 16'({if_s.LRCLK, if_u.LRCLK}),         16'h0);
    chk({tag, "_SDIN"},  16'({if_s.SDIN, if_u.SDIN}),           16'h0);
    chk({tag, "_FREQ"},  16'({if_s.frame_req, if_u.frame_req}), 16'h0);
  endtask

  task automatic drive_s(input logic [15:0] l, input logic [15:0] r);
    if_s.snd_left = l;
    if_s.snd_right = r;
    if_s.sample_stb = 1'b1;
  endtask

  task automatic drive_u(input logic [15:0] l, input logic [15:0] r);
    if_u.snd_left = l;
    if_u.snd_right = r;
    if_u.sample_stb = 1'b1;
  endtask

  task automatic run(input int n, input bit stim);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
      check_cycle();
      if_s.sample_stb = 1'b0;
      if_u.sample_stb = 1'b0;
      if (stim) begin
        case (k)
          4:    drive_s(S0L, S0R);
          8:    drive_u(16'h0000, 16'hFFFF);
          520:  drive_s(S1L, S1R);
          1200: drive_s(S2L, S2R);
          1201: drive_s(S3L, S3R);
          default: ;
        endcase
      end
    end
  endtask

  initial begin
`ifdef JTFRAME_I2S_MONO_EN
    exp_sl = '{16'h4000, 16'h4000, 16'h8000, 16'hFFFF, 16'hFFFF};
    exp_sr = '{16'h4000, 16'h4000, 16'h8000, 16'hFFFF, 16'hFFFF};
    exp_ul = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    exp_ur = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`else
    exp_sl = '{16'hA5C3, 16'hA5C3, 16'h1234, 16'h0F0F, 16'h0F0F};
    exp_sr = '{16'h0001, 16'h0001, 16'h0001, 16'hF0F0, 16'hF0F0};
    exp_ul = '{16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    exp_ur = '{16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
`endif
    if_s.snd_left = '0; if_s.snd_right = '0; if_s.sample_stb = 1'b0;
    if_u.snd_left = '0; if_u.snd_right = '0; if_u.sample_stb = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("RST0");
    rst_n = 1'b1;
    k = 0;
    run(2220, 1'b1);

    // k=2220 sits at bit_cnt 20 of the fifth frame with SCLK high.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("RSTMID");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset("RSTHOLD");
    end

    for (int i = 0; i < 5; i++) begin
      exp_sl[i] = '0; exp_sr[i] = '0; exp_ul[i] = '0; exp_ur[i] = '0;
    end
    rst_n = 1'b1;
    k = 0;
    run(600, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
